// File: rtl/axis_width_downsizer.sv
// Wide-to-narrow AXI-Stream width converter: each wide beat is held and emitted as its
// non-null narrow slices, lowest slice first, with no bubbles between slices or beats.
module axis_width_downsizer #(
   parameter int unsigned M_TDATA_WIDTH        = 4,
   parameter int unsigned RATIO                = 4,
   parameter int unsigned TID_WIDTH            = 1,
   parameter int unsigned TDEST_WIDTH          = 1,
   parameter int unsigned TUSER_WIDTH_PER_BYTE = 1
) (
   input  logic                                              aclk,
   input  logic                                              aresetn,
   input  logic                                              s_axis_tvalid,
   output logic                                              s_axis_tready,
   input  logic [M_TDATA_WIDTH*RATIO*8-1:0]                  s_axis_tdata,
   input  logic [M_TDATA_WIDTH*RATIO-1:0]                    s_axis_tstrb,
   input  logic [M_TDATA_WIDTH*RATIO-1:0]                    s_axis_tkeep,
   input  logic                                              s_axis_tlast,
   input  logic [TID_WIDTH-1:0]                              s_axis_tid,
   input  logic [TDEST_WIDTH-1:0]                            s_axis_tdest,
   input  logic [M_TDATA_WIDTH*RATIO*TUSER_WIDTH_PER_BYTE-1:0] s_axis_tuser,
   output logic                                              m_axis_tvalid,
   input  logic                                              m_axis_tready,
   output logic [M_TDATA_WIDTH*8-1:0]                        m_axis_tdata,
   output logic [M_TDATA_WIDTH-1:0]                          m_axis_tstrb,
   output logic [M_TDATA_WIDTH-1:0]                          m_axis_tkeep,
   output logic                                              m_axis_tlast,
   output logic [TID_WIDTH-1:0]                              m_axis_tid,
   output logic [TDEST_WIDTH-1:0]                            m_axis_tdest,
   output logic [M_TDATA_WIDTH*TUSER_WIDTH_PER_BYTE-1:0]     m_axis_tuser
);

   localparam int unsigned S_BYTES = M_TDATA_WIDTH * RATIO;
   localparam int unsigned M_DW    = M_TDATA_WIDTH * 8;
   localparam int unsigned M_UW    = M_TDATA_WIDTH * TUSER_WIDTH_PER_BYTE;
   localparam int unsigned IDX_W   = $clog2(RATIO);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_SEND  = 1'b1;

   logic [0:0]             state_q;
   logic [IDX_W-1:0]       idx_q;
   logic [S_BYTES*8-1:0]   hold_data_q;
   logic [S_BYTES-1:0]     hold_strb_q;
   logic [S_BYTES-1:0]     hold_keep_q;
   logic                   hold_last_q;
   logic [TID_WIDTH-1:0]   hold_id_q;
   logic [TDEST_WIDTH-1:0] hold_dest_q;
   logic [S_BYTES*TUSER_WIDTH_PER_BYTE-1:0] hold_user_q;

   logic [RATIO-1:0] in_nz;
   logic [RATIO-1:0] hold_nz;
   logic [IDX_W-1:0] first_idx;
   logic             first_found;
   logic [IDX_W-1:0] next_idx;
   logic             more_pending;
   logic             s_accept;
   logic             load;
   int unsigned      sel;

   // Priority finds: lowest non-null slice of the incoming beat, and the lowest non-null
   // slice of the held beat above the current index.
   always_comb begin
      in_nz        = '0;
      hold_nz      = '0;
      first_idx    = '0;
      first_found  = 1'b0;
      next_idx     = '0;
      more_pending = 1'b0;
      for (int k = 0; k < int'(RATIO); k++) begin
         in_nz[k]   = |s_axis_tkeep[k*M_TDATA_WIDTH +: M_TDATA_WIDTH];
         hold_nz[k] = |hold_keep_q[k*M_TDATA_WIDTH +: M_TDATA_WIDTH];
      end
      for (int k = int'(RATIO) - 1; k >= 0; k--) begin
         if (in_nz[k]) begin
            first_idx   = IDX_W'(k);
            first_found = 1'b1;
         end
         if (hold_nz[k] && (k > int'(idx_q))) begin
            next_idx     = IDX_W'(k);
            more_pending = 1'b1;
         end
      end
   end

   // Final-slice acceptance opens the input so the next wide beat loads without a gap.
   assign s_axis_tready = aresetn &&
                          ((state_q == ST_EMPTY) || (m_axis_tready && !more_pending));
   assign s_accept      = s_axis_tvalid && s_axis_tready;
   assign load          = s_accept && (first_found || s_axis_tlast);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q     <= ST_EMPTY;
         idx_q       <= '0;
         hold_data_q <= '0;
         hold_strb_q <= '0;
         hold_keep_q <= '0;
         hold_last_q <= 1'b0;
         hold_id_q   <= '0;
         hold_dest_q <= '0;
         hold_user_q <= '0;
      end else if (load) begin
         state_q     <= ST_SEND;
         idx_q       <= first_found ? first_idx : '0;
         hold_data_q <= s_axis_tdata;
         hold_strb_q <= s_axis_tstrb;
         hold_keep_q <= s_axis_tkeep;
         hold_last_q <= s_axis_tlast;
         hold_id_q   <= s_axis_tid;
         hold_dest_q <= s_axis_tdest;
         hold_user_q <= s_axis_tuser;
      end else if ((state_q == ST_SEND) && m_axis_tready) begin
         if (more_pending) begin
            idx_q <= next_idx;
         end else begin
            state_q <= ST_EMPTY;
         end
      end
   end

   always_comb begin
      sel           = 32'(idx_q);
      m_axis_tvalid = (state_q == ST_SEND);
      m_axis_tdata  = hold_data_q[sel*M_DW +: M_DW];
      m_axis_tstrb  = hold_strb_q[sel*M_TDATA_WIDTH +: M_TDATA_WIDTH];
      m_axis_tkeep  = hold_keep_q[sel*M_TDATA_WIDTH +: M_TDATA_WIDTH];
      m_axis_tuser  = hold_user_q[sel*M_UW +: M_UW];
      m_axis_tlast  = hold_last_q && !more_pending;
      m_axis_tid    = hold_id_q;
      m_axis_tdest  = hold_dest_q;
   end

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Scoreboard bench for axis_width_downsizer at default parameters (4-byte slices, ratio 4).
module tb_axis_width_downsizer;

   localparam int M = 4;
   localparam int R = 4;
   localparam int S = M * R;

   typedef struct {
      logic [M*8-1:0] data;
      logic [M-1:0]   strb;
      logic [M-1:0]   keep;
      logic           last;
      logic           id;
      logic           dest;
      logic [M-1:0]   user;
      logic           fin;
   } exp_t;

   logic           clk = 1'b0;
   logic           aresetn = 1'b0;
   logic           s_tvalid = 1'b0;
   logic           s_tready;
   logic [S*8-1:0] s_tdata = '0;
   logic [S-1:0]   s_tstrb = '0;
   logic [S-1:0]   s_tkeep = '0;
   logic           s_tlast = 1'b0;
   logic           s_tid = 1'b0;
   logic           s_tdest = 1'b0;
   logic [S-1:0]   s_tuser = '0;
   logic           m_tvalid;
   logic           m_tready = 1'b1;
   logic [M*8-1:0] m_tdata;
   logic [M-1:0]   m_tstrb;
   logic [M-1:0]   m_tkeep;
   logic           m_tlast;
   logic           m_tid;
   logic           m_tdest;
   logic [M-1:0]   m_tuser;

   exp_t q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int bp_mode = 0;
   int xfer_cnt = 0;
   int first_xfer_cyc = 0;
   int last_xfer_cyc = 0;
   int in_last_cnt = 0;
   int out_last_cnt = 0;
   logic           stalled = 1'b0;
   logic [M*8-1:0] st_data;
   logic [M-1:0]   st_keep;
   logic           st_last;

   axis_width_downsizer dut (
      .aclk          (clk),
      .aresetn       (aresetn),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tdata  (s_tdata),
      .s_axis_tstrb  (s_tstrb),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tlast  (s_tlast),
      .s_axis_tid    (s_tid),
      .s_axis_tdest  (s_tdest),
      .s_axis_tuser  (s_tuser),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tstrb  (m_tstrb),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tlast  (m_tlast),
      .m_axis_tid    (m_tid),
      .m_axis_tdest  (m_tdest),
      .m_axis_tuser  (m_tuser)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: one expected narrow beat per non-null slice; an all-null tlast beat
   // still yields a single zero-keep tlast beat from slice 0.
   function automatic void push_model(input logic [S*8-1:0] d, input logic [S-1:0] st,
                                      input logic [S-1:0] kp, input logic l, input logic id,
                                      input logic dest, input logic [S-1:0] u);
      int   lastnz;
      exp_t e;
      lastnz = -1;
      for (int k = 0; k < R; k++) if (kp[k*M +: M] != '0) lastnz = k;
      if (lastnz < 0) begin
         if (l) begin
            e = '{d[M*8-1:0], st[M-1:0], '0, 1'b1, id, dest, u[M-1:0], 1'b1};
            q.push_back(e);
         end
      end else begin
         for (int k = 0; k <= lastnz; k++) begin
            if (kp[k*M +: M] != '0) begin
               e = '{d[k*M*8 +: M*8], st[k*M +: M], kp[k*M +: M], l && (k == lastnz), id,
                     dest, u[k*M +: M], k == lastnz};
               q.push_back(e);
            end
         end
      end
   endfunction

   // Leaves s_tvalid high on return so consecutive calls stream back to back.
   task automatic drive(input logic [S*8-1:0] d, input logic [S-1:0] st, input logic [S-1:0] kp,
                        input logic l, input logic id, input logic dest, input logic [S-1:0] u);
      bit ok;
      s_tdata = d; s_tstrb = st; s_tkeep = kp; s_tlast = l;
      s_tid = id; s_tdest = dest; s_tuser = u; s_tvalid = 1'b1;
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk);
         if (s_tready) begin
            push_model(d, st, kp, l, id, dest, u);
            ok = 1;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check("drive_timeout", s_tready, 1);
   endtask

   task automatic idle();
      s_tvalid = 1'b0;
   endtask

   task automatic mark();
      xfer_cnt = 0; in_last_cnt = 0; out_last_cnt = 0;
   endtask

   task automatic drain();
      for (int c = 0; c < 400; c++) begin
         if (q.size() == 0 && !m_tvalid) break;
         @(posedge clk);
         #1;
      end
      check("drain_q", q.size(), 0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode == 0) m_tready = 1'b1;
         else if (bp_mode == 1) m_tready = 1'($urandom_range(0, 1));
      end
   end

   always @(negedge clk) begin
      if (aresetn) begin
         if (stalled) begin
            check("stall_valid", m_tvalid, 1);
            check("stall_data", m_tdata, st_data);
            check("stall_keep", m_tkeep, st_keep);
            check("stall_last", m_tlast, st_last);
         end
         if (m_tvalid) check("s_rdy_send", s_tready, m_tready && q.size() > 0 && q[0].fin);
         else check("s_rdy_idle", s_tready, 1);
         if (m_tvalid && m_tready) begin
            stalled = 1'b0;
            if (q.size() == 0) begin
               check("unexpected_beat", q.size(), 1);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("tdata", m_tdata, e.data);
               check("tstrb", m_tstrb, e.strb);
               check("tkeep", m_tkeep, e.keep);
               check("tlast", m_tlast, e.last);
               check("tid", m_tid, e.id);
               check("tdest", m_tdest, e.dest);
               check("tuser", m_tuser, e.user);
            end
            if (xfer_cnt == 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            xfer_cnt++;
            if (m_tlast) out_last_cnt++;
         end else if (m_tvalid) begin
            stalled = 1'b1;
            st_data = m_tdata; st_keep = m_tkeep; st_last = m_tlast;
         end else begin
            stalled = 1'b0;
         end
      end
   end

   initial begin
      logic [S*8-1:0] d;
      logic [S-1:0]   kp;
      logic [3:0]     r4;
      logic           l;

      // Reset state
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_s_rdy", s_tready, 0);
      check("rst_m_valid", m_tvalid, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_tkeep", m_tkeep, 0);
      check("rst_tlast", m_tlast, 0);
      @(posedge clk); #1;
      aresetn = 1'b1;
      @(negedge clk);
      check("post_rst_s_rdy", s_tready, 1);
      @(posedge clk); #1;

      // Full beat, bytes 0x00..0x0F
      for (int i = 0; i < S; i++) d[i*8 +: 8] = 8'(i);
      mark();
      drive(d, '1, '1, 1'b1, 1'b1, 1'b0, 16'hA5C3);
      idle();
      drain();
      check("t1_count", xfer_cnt, 4);
      check("t1_span", last_xfer_cyc - first_xfer_cyc, 3);
      check("t1_lasts", out_last_cnt, 1);

      // Null slices 1 and 3 skipped without a gap
      mark();
      drive(d, 16'hFFFF, 16'h0F0F, 1'b1, 1'b0, 1'b1, 16'h1234);
      idle();
      drain();
      check("t2_count", xfer_cnt, 2);
      check("t2_span", last_xfer_cyc - first_xfer_cyc, 1);

      // All-null beat without tlast is dropped
      mark();
      drive(d, '1, '0, 1'b0, 1'b0, 1'b0, '0);
      idle();
      repeat (5) @(posedge clk);
      #1;
      check("t3_dropped", xfer_cnt, 0);

      // All-null beat with tlast gives one zero-keep tlast beat
      mark();
      drive(d, '1, '0, 1'b1, 1'b1, 1'b1, '0);
      idle();
      drain();
      check("t4_count", xfer_cnt, 1);
      check("t4_lasts", out_last_cnt, 1);

      // Back-to-back wide beats
      mark();
      drive(d, '1, '1, 1'b0, 1'b0, 1'b1, 16'h0F0F);
      drive(~d, '1, '1, 1'b1, 1'b1, 1'b0, 16'hF0F0);
      idle();
      drain();
      check("t5_count", xfer_cnt, 8);
      check("t5_span", last_xfer_cyc - first_xfer_cyc, 7);

      // Random traffic under 50% backpressure
      bp_mode = 1;
      mark();
      for (int n = 0; n < 1000; n++) begin
         for (int w = 0; w < S / 4; w++) d[w*32 +: 32] = $urandom;
         for (int k = 0; k < R; k++) begin
            r4 = 4'($urandom);
            case ($urandom_range(0, 3))
               0: kp[k*M +: M] = '0;
               2: kp[k*M +: M] = r4;
               default: kp[k*M +: M] = '1;
            endcase
         end
         l = 1'($urandom_range(0, 1));
         if (l) in_last_cnt++;
         drive(d, 16'($urandom), kp, l, 1'($urandom), 1'($urandom), 16'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk); #1;
         end
      end
      idle();
      drain();
      check("rand_tlast_count", out_last_cnt, in_last_cnt);
      bp_mode = 0;
      @(posedge clk); #1;

      // Reset after first slice is accepted
      bp_mode = 2;
      m_tready = 1'b0;
      for (int i = 0; i < S; i++) d[i*8 +: 8] = 8'(8'h40 + i);
      drive(d, '1, '1, 1'b1, 1'b1, 1'b1, '1);
      idle();
      m_tready = 1'b1;
      @(posedge clk); #1;
      m_tready = 1'b0;
      aresetn = 1'b0;
      @(posedge clk); #1;
      aresetn = 1'b1;
      q.delete();
      stalled = 1'b0;
      @(negedge clk);
      check("rst_mid_valid", m_tvalid, 0);
      check("rst_mid_tdata", m_tdata, 0);
      @(posedge clk); #1;
      bp_mode = 0;
      m_tready = 1'b1;
      for (int i = 0; i < S; i++) d[i*8 +: 8] = 8'(8'h80 + i);
      mark();
      drive(d, '1, '1, 1'b1, 1'b0, 1'b0, '0);
      idle();
      drain();
      check("rst_next_count", xfer_cnt, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
